// File: rtl/pc_ctrl.sv
// Program counter with branch/jump/call/return selection and a circular return-address stack.
// Overflowing calls overwrite the oldest return address; returns on an empty stack fall through.
module pc_ctrl #(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [4:0]       ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  localparam logic [2:0] ModeBranch = 3'd1;
  localparam logic [2:0] ModeJump   = 3'd2;
  localparam logic [2:0] ModeCall   = 3'd3;
  localparam logic [2:0] ModeRet    = 3'd4;

  localparam logic [4:0]      CountMax = 5'(RAS_DEPTH);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(RAS_DEPTH - 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [4:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_seq;
  logic [PtrW-1:0]  ptr_inc, ptr_dec;
  logic             push;

  assign pc_seq  = pc_q + WIDTH'(STEP);
  // ptr_q names the next free slot; when full it also names the oldest entry.
  assign ptr_inc = (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);
  assign ptr_dec = (ptr_q == '0) ? PtrLast : ptr_q - PtrW'(1);

  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!stall) begin
      case (mode)
        ModeBranch: pc_d = pc_q + offset;
        ModeJump:   pc_d = target;
        ModeCall: begin
          push  = 1'b1;
          pc_d  = target;
          ptr_d = ptr_inc;
          if (count_q == CountMax) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 5'd1;
          end
        end
        ModeRet: begin
          if (count_q == '0) begin
            pc_d  = pc_seq;
            unf_d = 1'b1;
          end else begin
            pc_d    = ras_q[ptr_dec];
            ptr_d   = ptr_dec;
            count_d = count_q - 5'd1;
          end
        end
        default: pc_d = pc_seq;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_ADDR;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is not reset; entries are unreachable while the count is zero.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ras_q[ptr_q] <= pc_seq;
    end
  end

  assign pc        = pc_q;
  assign ras_count = count_q;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CountMax);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic against a
// queue-based model of the program counter and return-address stack.
module tb_pc_ctrl;

  localparam int unsigned Depth = 4;

  localparam logic [2:0] MSeq    = 3'd0;
  localparam logic [2:0] MBranch = 3'd1;
  localparam logic [2:0] MJump   = 3'd2;
  localparam logic [2:0] MCall   = 3'd3;
  localparam logic [2:0] MRet    = 3'd4;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  mode;
  logic [31:0] offset;
  logic [31:0] target;
  logic [31:0] pc;
  logic [4:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  pc_ctrl #(
    .WIDTH     (32),
    .STEP      (4),
    .RESET_ADDR(32'h0),
    .RAS_DEPTH (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .mode     (mode),
    .offset   (offset),
    .target   (target),
    .pc       (pc),
    .ras_count(ras_count),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: return addresses kept newest-last in a queue.
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_ovf;
  logic        m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic [2:0] md, input logic [31:0] off,
                            input logic [31:0] tgt);
    if (st) return;
    case (md)
      MBranch: m_pc = m_pc + off;
      MJump:   m_pc = tgt;
      MCall: begin
        if (m_stack.size() == Depth) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(m_pc + 32'd4);
        m_pc = tgt;
      end
      MRet: begin
        if (m_stack.size() == 0) begin
          m_pc  = m_pc + 32'd4;
          m_unf = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end
      default: m_pc = m_pc + 32'd4;
    endcase
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_stack.size();
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".cnt"}, 32'(ras_count), 32'(n));
    check({tag, ".empty"}, 32'(ras_empty), 32'(n == 0));
    check({tag, ".full"}, 32'(ras_full), 32'(n == Depth));
    check({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
    check({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
  endtask

  // Drives one cycle's inputs, advances the model at the edge, then compares.
  task automatic cycle(input string tag, input logic st, input logic [2:0] md,
                       input logic [31:0] off, input logic [31:0] tgt);
    stall  = st;
    mode   = md;
    offset = off;
    target = tgt;
    @(posedge clk);
    model_step(st, md, off, tgt);
    #1;
    check_all(tag);
  endtask

  // Asserts reset between edges and checks the state clears before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    stall  = 1'b0;
    mode   = MSeq;
    offset = '0;
    target = '0;
    model_reset();
    #3;
    check_all("rst");
    @(negedge clk);
    reset = 1'b1;

    // Sequential stepping.
    cycle("seq1", 1'b0, MSeq, '0, '0);
    cycle("seq2", 1'b0, MSeq, '0, '0);
    cycle("seq3", 1'b0, MSeq, '0, '0);
    check("seq.pc12", pc, 32'd12);

    // Branch backwards, jump to top of address space, wrap on SEQ.
    cycle("br", 1'b0, MBranch, -32'sd8, '0);
    check("br.pc4", pc, 32'd4);
    cycle("jmp", 1'b0, MJump, '0, 32'hFFFF_FFFC);
    cycle("wrap", 1'b0, MSeq, '0, '0);
    check("wrap.pc0", pc, 32'h0);

    // Nested call/return.
    cycle("j100", 1'b0, MJump, '0, 32'h100);
    cycle("call1", 1'b0, MCall, '0, 32'h200);
    cycle("call2", 1'b0, MCall, '0, 32'h300);
    cycle("ret1", 1'b0, MRet, '0, '0);
    check("ret1.pc204", pc, 32'h204);
    cycle("ret2", 1'b0, MRet, '0, '0);
    check("ret2.pc104", pc, 32'h104);

    // Five calls overflow a four-entry stack; four returns give the newest in LIFO order.
    for (int i = 0; i < 5; i++) cycle("ovfcall", 1'b0, MCall, '0, 32'h1000 * (i + 1));
    check("ovf.flag", 32'(ras_ovf), 32'd1);
    check("ovf.cnt4", 32'(ras_count), 32'd4);
    for (int i = 0; i < 4; i++) cycle("ovfret", 1'b0, MRet, '0, '0);

    // Return on empty stack, then stall holds everything.
    cycle("j40", 1'b0, MJump, '0, 32'h40);
    cycle("unfret", 1'b0, MRet, '0, '0);
    check("unf.pc44", pc, 32'h44);
    check("unf.flag", 32'(ras_unf), 32'd1);
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, MJump, '0, 32'hDEAD_BEEC);
    check("stall.pc44", pc, 32'h44);
    cycle("unfsticky", 1'b0, MSeq, '0, '0);

    // Mid-cycle reset with two live entries, asserted while stalled.
    cycle("j100b", 1'b0, MJump, '0, 32'h100);
    cycle("c200", 1'b0, MCall, '0, 32'h200);
    cycle("c300", 1'b0, MCall, '0, 32'h300);
    stall = 1'b1;
    async_reset("midrst");
    check("midrst.pc0", pc, 32'h0);
    stall = 1'b0;
    cycle("postrst", 1'b0, MSeq, '0, '0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      logic        st;
      logic [2:0]  md;
      logic [31:0] off;
      logic [31:0] tgt;
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rndrst");
      end else begin
        st  = ($urandom_range(0, 7) == 0);
        md  = 3'($urandom_range(0, 7));
        off = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed(8'($urandom())));
        tgt = $urandom();
        cycle("rnd", st, md, off, tgt);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, bit width of all addresses and offsets.
REQ-002 Parameter STEP, default 4, sequential increment added to pc.
REQ-003 Parameter RESET_ADDR, default 0, pc value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; the legal range is 2..16.
REQ-005 Port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-007 Port stall, input, 1 bit, 1 = hold all state this cycle.
REQ-008 Port mode, input, 3 bits, next-pc select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET; 5-7 are treated as SEQ.
REQ-009 Port offset, input, WIDTH bits, two's-complement displacement used by BRANCH.
REQ-010 Port target, input, WIDTH bits, absolute address used by JUMP and CALL.
REQ-011 Port pc, output, WIDTH bits, current program counter (registered).
REQ-012 Port ras_count, output, 5 bits, number of valid stack entries (0..RAS_DEPTH).
REQ-013 Port ras_empty, output, 1 bit, high when ras_count == 0.
REQ-014 Port ras_full, output, 1 bit, high when ras_count == RAS_DEPTH.
REQ-015 Port ras_ovf, output, 1 bit, sticky flag set by a CALL issued while the stack is full.
REQ-016 Port ras_unf, output, 1 bit, sticky flag set by a RET issued while the stack is empty.

Function
REQ-017 pc, ras_count, the stack pointer, ras_ovf and ras_unf SHALL update only on the rising clk edge while reset is high; the latency from mode to pc is 1 cycle.
REQ-018 stall=1 SHALL hold pc, the stack contents, pointer, count and flags unchanged, regardless of mode.
REQ-019 SEQ: pc <= pc + STEP.
REQ-020 BRANCH: pc <= pc + offset.
REQ-021 JUMP: pc <= target.
REQ-022 CALL: push pc + STEP onto the stack, then pc <= target; ras_count increments.
REQ-023 RET with the stack non-empty: pc <= top entry, pop; ras_count decrements.
REQ-024 All address arithmetic SHALL be modulo 2^WIDTH; carries are discarded and no flag is raised on wrap.
REQ-025 The stack SHALL be circular. A CALL while full SHALL overwrite the oldest entry, leave ras_count at RAS_DEPTH, and set ras_ovf.
REQ-026 RET while empty SHALL behave as SEQ (pc <= pc + STEP), leave the stack unchanged, and set ras_unf.
REQ-027 ras_ovf and ras_unf SHALL remain set until reset; no other clear exists.
REQ-028 ras_empty and ras_full SHALL be combinational decodes of ras_count.
REQ-029 mode, offset and target SHALL be sampled only at the clock edge; there is no combinational path from inputs to pc.

Reset
REQ-030 Asserting reset low SHALL immediately, without waiting for clk, set pc=RESET_ADDR, ras_count=0, the stack pointer to 0, ras_ovf=0 and ras_unf=0.
REQ-031 Stack entry contents need not be cleared on reset; entries are unreachable while ras_count=0.
REQ-032 Reset asserted mid-sequence, including during stall, SHALL take priority over every other input; the first update after release occurs on the first rising edge with reset high.

Verification
REQ-033 Reset then SEQ for 3 cycles (defaults) -> pc 0, 4, 8, 12; ras_empty=1.
REQ-034 pc=12, BRANCH with offset=-8 -> pc=4; JUMP with target=0xFFFFFFFC then SEQ -> pc=0xFFFFFFFC then 0x00000000 (wrap).
REQ-035 From pc=0x100: CALL target=0x200, then CALL target=0x300, then RET, then RET -> pc 0x200, 0x300, 0x204, 0x104; ras_count 1, 2, 1, 0.
REQ-036 Five CALLs with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1, ras_count=4; four RETs return the four newest return addresses in LIFO order.
REQ-037 RET on an empty stack at pc=0x40 -> pc=0x44, ras_unf=1 and it stays set; stall=1 held for 3 cycles with mode=JUMP -> pc unchanged.
REQ-038 Reset pulsed low between clk edges while ras_count=2 and pc=0x300 -> pc=0 and ras_count=0 before the next edge; ras_ovf and ras_unf clear.
